// File: rtl/axil_master_pkg.sv
// Shared state encodings and AXI-Lite response codes for the command-queue master.
package axil_master_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t WR_AW_W = 3'd1;
  localparam state_t WR_B    = 3'd2;
  localparam state_t RD_AR   = 3'd3;
  localparam state_t RD_R    = 3'd4;
  localparam state_t RSP     = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  function automatic logic is_wait_state(input state_t s);
    return (s == WR_AW_W) || (s == WR_B) || (s == RD_AR) || (s == RD_R);
  endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Per-state wait counter; flags expiry on the last allowed cycle of a wait state.
module axil_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  if (TIMEOUT_CYCLES > 0) begin : g_wd
    logic [TO_WIDTH-1:0] cnt;
    logic                at_last;

    assign at_last = (cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        cnt <= '0;
      end else if (clr_i) begin
        cnt <= '0;
      end else if (en_i && !at_last) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign expired_o = en_i && at_last;
  end else begin : g_off
    assign expired_o = 1'b0;
  end

endmodule

// File: rtl/axil_master_cmdq.sv
// Single-outstanding AXI-Lite master: one command in, one response out, with
// independent AW/W tracking, early-B capture and an optional per-state watchdog.
module axil_master_cmdq
  import axil_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_write_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  output logic                  rsp_timeout_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] axil_awaddr,
  output logic [2:0]            axil_awprot,
  output logic                  axil_awvalid,
  input  logic                  axil_awready,
  output logic [DATA_WIDTH-1:0] axil_wdata,
  output logic [STRB_WIDTH-1:0] axil_wstrb,
  output logic                  axil_wvalid,
  input  logic                  axil_wready,
  input  logic [1:0]            axil_bresp,
  input  logic                  axil_bvalid,
  output logic                  axil_bready,
  output logic [ADDR_WIDTH-1:0] axil_araddr,
  output logic [2:0]            axil_arprot,
  output logic                  axil_arvalid,
  input  logic                  axil_arready,
  input  logic [DATA_WIDTH-1:0] axil_rdata,
  input  logic [1:0]            axil_rresp,
  input  logic                  axil_rvalid,
  output logic                  axil_rready
);

  state_t state;
  logic   aw_done, w_done, b_done;
  logic   aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic   aw_now, w_now, b_now;
  logic   leave, expired, abort, wd_clr, wd_en;

  assign axil_awprot = '0;
  assign axil_arprot = '0;
  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign rsp_valid_o = (state == RSP);

  always_comb begin
    aw_fire = axil_awvalid & axil_awready;
    w_fire  = axil_wvalid & axil_wready;
    b_fire  = axil_bvalid & axil_bready;
    ar_fire = axil_arvalid & axil_arready;
    r_fire  = axil_rvalid & axil_rready;
    aw_now  = aw_done | aw_fire;
    w_now   = w_done | w_fire;
    b_now   = b_done | b_fire;
    leave   = ((state == WR_AW_W) && aw_now && w_now) ||
              ((state == WR_B) && b_fire) ||
              ((state == RD_AR) && ar_fire) ||
              ((state == RD_R) && r_fire);
    // A completing handshake in the expiry cycle takes priority over the abort.
    abort   = expired && !leave;
    wd_en   = is_wait_state(state);
    wd_clr  = ((state == IDLE) && cmd_valid_i) ||
              ((state == WR_AW_W) && aw_now && w_now && !b_now) ||
              ((state == RD_AR) && ar_fire && !r_fire);
  end

  axil_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_WIDTH      (TO_WIDTH)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      b_done        <= 1'b0;
      axil_awaddr   <= '0;
      axil_awvalid  <= 1'b0;
      axil_wdata    <= '0;
      axil_wstrb    <= '0;
      axil_wvalid   <= 1'b0;
      axil_bready   <= 1'b0;
      axil_araddr   <= '0;
      axil_arvalid  <= 1'b0;
      axil_rready   <= 1'b0;
      rsp_write_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_resp_o    <= RESP_OKAY;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            rsp_write_o <= cmd_write_i;
            if (cmd_write_i == CMD_WRITE) begin
              axil_awaddr  <= cmd_addr_i;
              axil_wdata   <= cmd_wdata_i;
              axil_wstrb   <= cmd_wstrb_i;
              axil_awvalid <= 1'b1;
              axil_wvalid  <= 1'b1;
              axil_bready  <= 1'b1;
              aw_done      <= 1'b0;
              w_done       <= 1'b0;
              b_done       <= 1'b0;
              state        <= WR_AW_W;
            end else begin
              axil_araddr  <= cmd_addr_i;
              axil_arvalid <= 1'b1;
              axil_rready  <= 1'b1;
              state        <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          if (aw_fire) begin
            axil_awvalid <= 1'b0;
            aw_done      <= 1'b1;
          end
          if (w_fire) begin
            axil_wvalid <= 1'b0;
            w_done      <= 1'b1;
          end
          if (b_fire) begin
            axil_bready   <= 1'b0;
            b_done        <= 1'b1;
            rsp_resp_o    <= axil_bresp;
            rsp_rdata_o   <= '0;
            rsp_timeout_o <= 1'b0;
          end
          if (aw_now && w_now) state <= b_now ? RSP : WR_B;
        end
        WR_B: begin
          if (b_fire) begin
            axil_bready   <= 1'b0;
            rsp_resp_o    <= axil_bresp;
            rsp_rdata_o   <= '0;
            rsp_timeout_o <= 1'b0;
            state         <= RSP;
          end
        end
        RD_AR: begin
          if (ar_fire) begin
            axil_arvalid <= 1'b0;
            if (r_fire) begin
              axil_rready   <= 1'b0;
              rsp_rdata_o   <= axil_rdata;
              rsp_resp_o    <= axil_rresp;
              rsp_timeout_o <= 1'b0;
              state         <= RSP;
            end else begin
              state <= RD_R;
            end
          end
        end
        RD_R: begin
          if (r_fire) begin
            axil_rready   <= 1'b0;
            rsp_rdata_o   <= axil_rdata;
            rsp_resp_o    <= axil_rresp;
            rsp_timeout_o <= 1'b0;
            state         <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Watchdog abort overrides whatever the wait state did this cycle.
      if (abort) begin
        axil_awvalid  <= 1'b0;
        axil_wvalid   <= 1'b0;
        axil_bready   <= 1'b0;
        axil_arvalid  <= 1'b0;
        axil_rready   <= 1'b0;
        rsp_resp_o    <= RESP_SLVERR;
        rsp_rdata_o   <= '0;
        rsp_timeout_o <= 1'b1;
        state         <= RSP;
      end
    end
  end

endmodule

// File: tb/tb_axil_master_cmdq.sv
// Directed bench: table of zero-wait transactions plus scripted wait/timeout/reset cases.
module tb_axil_master_cmdq;

  logic        clk, rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  // Slave: auto mode is a zero-wait combinational responder, manual mode is scripted.
  logic        auto_mode;
  logic [31:0] a_rdata;
  logic [1:0]  a_resp;
  logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;

  assign awready = auto_mode ? 1'b1 : m_awready;
  assign wready  = auto_mode ? 1'b1 : m_wready;
  assign bvalid  = auto_mode ? (awvalid & wvalid) : m_bvalid;
  assign bresp   = auto_mode ? a_resp : m_bresp;
  assign arready = auto_mode ? 1'b1 : m_arready;
  assign rvalid  = auto_mode ? arvalid : m_rvalid;
  assign rdata   = auto_mode ? a_rdata : m_rdata;
  assign rresp   = auto_mode ? a_resp : m_rresp;

  axil_master_cmdq #(
    .ADDR_WIDTH    (4),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_write_i  (cmd_write),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_wstrb_i  (cmd_wstrb),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_write_o  (rsp_write),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_resp_o   (rsp_resp),
    .rsp_timeout_o(rsp_timeout),
    .busy_o       (busy),
    .axil_awaddr  (awaddr),
    .axil_awprot  (awprot),
    .axil_awvalid (awvalid),
    .axil_awready (awready),
    .axil_wdata   (wdata),
    .axil_wstrb   (wstrb),
    .axil_wvalid  (wvalid),
    .axil_wready  (wready),
    .axil_bresp   (bresp),
    .axil_bvalid  (bvalid),
    .axil_bready  (bready),
    .axil_araddr  (araddr),
    .axil_arprot  (arprot),
    .axil_arvalid (arvalid),
    .axil_arready (arready),
    .axil_rdata   (rdata),
    .axil_rresp   (rresp),
    .axil_rvalid  (rvalid),
    .axil_rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ar_cnt = 0;
  always @(posedge clk) if (arvalid) ar_cnt <= ar_cnt + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the cycle after acceptance.
  task automatic send_cmd(input logic wr, input logic [3:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("busy_after_rsp", 64'(busy), 64'd0);
    check("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
  endtask

  task automatic manual_idle();
    auto_mode = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = '0;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL global_time_limit: got simulation still running, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int ar0;
    int waited;

    vecs[0] = '{1'b1, 4'h4, 32'hDEADBEEF, 4'b0011, 32'h0,        2'b00, 32'h0};
    vecs[1] = '{1'b0, 4'h8, 32'h0,        4'b0000, 32'h12345678, 2'b00, 32'h12345678};
    vecs[2] = '{1'b1, 4'h0, 32'h00000000, 4'b1111, 32'hFFFFFFFF, 2'b11, 32'h0};
    vecs[3] = '{1'b0, 4'hC, 32'h0,        4'b0000, 32'hCAFEF00D, 2'b01, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 4'hF, 32'hFFFFFFFF, 4'b1000, 32'h0,        2'b01, 32'h0};
    vecs[5] = '{1'b0, 4'h1, 32'h0,        4'b0000, 32'hA5A5A5A5, 2'b10, 32'hA5A5A5A5};

    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    a_rdata = '0; a_resp = 2'b00;
    manual_idle();
    auto_mode = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    check("rst_addr_data", 64'({awaddr, araddr, wdata, wstrb}), 64'd0);
    check("rst_rsp_fields", 64'({rsp_write, rsp_rdata, rsp_resp, rsp_timeout}), 64'd0);
    check("prot", 64'({awprot, arprot}), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Zero-wait table: AXI valid in N+1, response in N+2.
    for (int i = 0; i < 6; i++) begin
      a_rdata = vecs[i].s_rdata;
      a_resp  = vecs[i].s_resp;
      send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      if (vecs[i].wr) begin
        check("v_awvalid", 64'({awvalid, wvalid, bready}), 64'b111);
        check("v_awaddr", 64'(awaddr), 64'(vecs[i].addr));
        check("v_wdata", 64'(wdata), 64'(vecs[i].wdata));
        check("v_wstrb", 64'(wstrb), 64'(vecs[i].wstrb));
      end else begin
        check("v_arvalid", 64'({arvalid, rready}), 64'b11);
        check("v_araddr", 64'(araddr), 64'(vecs[i].addr));
      end
      check("v_rsp_early", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check("v_rsp_valid", 64'(rsp_valid), 64'd1);
      check("v_rsp_write", 64'(rsp_write), 64'(vecs[i].wr));
      check("v_rsp_rdata", 64'(rsp_rdata), 64'(vecs[i].exp_rdata));
      check("v_rsp_resp", 64'(rsp_resp), 64'(vecs[i].s_resp));
      check("v_rsp_timeout", 64'(rsp_timeout), 64'd0);
      check("v_axi_idle", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
      finish_rsp();
    end

    // Read: arready after 3 wait cycles, rvalid 2 cycles after AR handshake.
    manual_idle();
    ar0 = ar_cnt;
    send_cmd(1'b0, 4'h8, 32'h0, 4'h0);
    for (int c = 1; c <= 4; c++) begin
      check("a_arvalid_hold", 64'(arvalid), 64'd1);
      check("a_cmd_ready", 64'(cmd_ready), 64'd0);
      if (c == 4) m_arready = 1'b1;
      @(negedge clk);
    end
    m_arready = 1'b0;
    check("a_arvalid_drop", 64'(arvalid), 64'd0);
    check("a_rready", 64'(rready), 64'd1);
    check("a_cmd_ready2", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'h12345678; m_rresp = 2'b00;
    check("a_cmd_ready3", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    m_rvalid = 1'b0;
    check("a_ar_cycles", 64'(ar_cnt - ar0), 64'd4);
    check("a_rsp_valid", 64'(rsp_valid), 64'd1);
    check("a_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
    check("a_rsp_resp", 64'(rsp_resp), 64'd0);
    check("a_rready_drop", 64'(rready), 64'd0);
    finish_rsp();

    // Read timeout: arready never comes, watchdog of 16 cycles.
    manual_idle();
    ar0 = ar_cnt;
    send_cmd(1'b0, 4'h2, 32'h0, 4'h0);
    waited = 0;
    while (!rsp_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("c_rsp_valid", 64'(rsp_valid), 64'd1);
    check("c_wait_cycles", 64'(waited), 64'd16);
    check("c_ar_cycles", 64'(ar_cnt - ar0), 64'd16);
    check("c_axi_idle", 64'({arvalid, rready}), 64'd0);
    check("c_timeout", 64'(rsp_timeout), 64'd1);
    check("c_resp", 64'(rsp_resp), 64'b10);
    check("c_rdata", 64'(rsp_rdata), 64'd0);
    finish_rsp();
    auto_mode = 1'b1; a_rdata = 32'h55AA55AA; a_resp = 2'b00;
    send_cmd(1'b0, 4'h3, 32'h0, 4'h0);
    @(negedge clk);
    check("c_next_valid", 64'(rsp_valid), 64'd1);
    check("c_next_rdata", 64'(rsp_rdata), 64'h55AA55AA);
    check("c_next_timeout", 64'(rsp_timeout), 64'd0);
    finish_rsp();

    // Write: W completes 5 cycles before AW; early B arrives with AW.
    manual_idle();
    m_wready = 1'b1;
    send_cmd(1'b1, 4'h4, 32'h0BADF00D, 4'b1100);
    check("b_both_valid", 64'({awvalid, wvalid}), 64'b11);
    @(negedge clk);
    m_wready = 1'b0;
    check("b_wvalid_drop", 64'(wvalid), 64'd0);
    check("b_awvalid_hold", 64'(awvalid), 64'd1);
    check("b_bready", 64'(bready), 64'd1);
    repeat (4) @(negedge clk);
    check("b_awvalid_late", 64'(awvalid), 64'd1);
    check("b_no_rsp", 64'(rsp_valid), 64'd0);
    m_awready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b10;
    @(negedge clk);
    m_awready = 1'b0; m_bvalid = 1'b0;
    check("b_axi_idle", 64'({awvalid, wvalid, bready}), 64'd0);
    check("b_rsp_valid", 64'(rsp_valid), 64'd1);
    check("b_rsp_resp", 64'(rsp_resp), 64'b10);
    check("b_rsp_write", 64'(rsp_write), 64'd1);
    check("b_rsp_timeout", 64'(rsp_timeout), 64'd0);
    finish_rsp();

    // Back-pressure: response held for 10 cycles.
    auto_mode = 1'b1; a_rdata = 32'h0F1E2D3C; a_resp = 2'b01;
    send_cmd(1'b0, 4'h6, 32'h0, 4'h0);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      check("d_rsp_valid", 64'(rsp_valid), 64'd1);
      check("d_rsp_rdata", 64'(rsp_rdata), 64'h0F1E2D3C);
      check("d_rsp_resp", 64'(rsp_resp), 64'b01);
      check("d_rsp_write", 64'(rsp_write), 64'd0);
      check("d_cmd_ready", 64'(cmd_ready), 64'd0);
      check("d_axi_idle", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
      @(negedge clk);
    end
    finish_rsp();

    // Asynchronous reset in the middle of a write.
    manual_idle();
    send_cmd(1'b1, 4'hA, 32'h11112222, 4'b1111);
    check("e_wvalid", 64'(wvalid), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("e_valids_async", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    check("e_busy_async", 64'(busy), 64'd0);
    check("e_regs_async", 64'({awaddr, wdata, wstrb}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("e_no_rsp", 64'(rsp_valid), 64'd0);
      check("e_idle", 64'(busy), 64'd0);
    end
    manual_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
